display_scanner: RTL and testbench

DISPLAY_SCANNER -- requirements
Module: display_scanner

---
 rtl/watch_pkg.sv | 38 +++
 rtl/bcd_to_seg.sv | 35 +++
 rtl/display_scanner.sv | 204 ++++++++++++++++++++
 tb/tb_display_scanner.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : watch_pkg
//  Description : Shared constants for the watch display path. Holds the scan
//                state encoding, the active-low 7-segment patterns
//                (bit 6..0 = a..g) and the all-anodes-off value.
//  Revision    : 1.0  initial release
// ============================================================================
package watch_pkg;

   // Scan state encoding
   typedef logic [2:0] scan_state_t;

   localparam scan_state_t ST_BLANK = 3'd0;
   localparam scan_state_t ST_SCAN0 = 3'd1;
   localparam scan_state_t ST_SCAN1 = 3'd2;
   localparam scan_state_t ST_SCAN2 = 3'd3;
   localparam scan_state_t ST_SCAN3 = 3'd4;

   // Active-low segment patterns, bit 6..0 = a..g
   localparam logic [6:0] C_SEG_0    = 7'h01;
   localparam logic [6:0] C_SEG_1    = 7'h4F;
   localparam logic [6:0] C_SEG_2    = 7'h12;
   localparam logic [6:0] C_SEG_3    = 7'h06;
   localparam logic [6:0] C_SEG_4    = 7'h4C;
   localparam logic [6:0] C_SEG_5    = 7'h24;
   localparam logic [6:0] C_SEG_6    = 7'h20;
   localparam logic [6:0] C_SEG_7    = 7'h0F;
   localparam logic [6:0] C_SEG_8    = 7'h00;
   localparam logic [6:0] C_SEG_9    = 7'h04;
   localparam logic [6:0] C_SEG_DASH = 7'h7E;
   localparam logic [6:0] C_SEG_OFF  = 7'h7F;

   // Active-low anodes, all digits dark
   localparam logic [3:0] C_AN_OFF   = 4'b1111;

endpackage : watch_pkg
`default_nettype wire

// File: rtl/bcd_to_seg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_seg
//  Description : Combinational BCD to active-low 7-segment decoder.
//                Codes 10..15 show a dash (segment g only).
//  Ports       : bcd_i [3:0]  BCD digit in
//                seg_o [6:0]  active-low segments, bit 6..0 = a..g
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_to_seg
   import watch_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = C_SEG_DASH;
      case (bcd_i)
         4'd0:    seg_o = C_SEG_0;
         4'd1:    seg_o = C_SEG_1;
         4'd2:    seg_o = C_SEG_2;
         4'd3:    seg_o = C_SEG_3;
         4'd4:    seg_o = C_SEG_4;
         4'd5:    seg_o = C_SEG_5;
         4'd6:    seg_o = C_SEG_6;
         4'd7:    seg_o = C_SEG_7;
         4'd8:    seg_o = C_SEG_8;
         4'd9:    seg_o = C_SEG_9;
         default: seg_o = C_SEG_DASH;
      endcase
   end

endmodule : bcd_to_seg
`default_nettype wire

// File: rtl/display_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : display_scanner
//  Description : Time-multiplexed driver for a 4-digit common-anode 7-segment
//                display. A prescaler sets how long each digit is lit; a
//                frame snapshot of the four BCD inputs is taken on every
//                entry to SCAN0 so a frame never mixes old and new digits.
//                In set mode the digits blink with a 1 Hz phase, and the
//                decimal point of digit 2 serves as the blinking colon.
//  Ports       : userclock        system clock (rising edge)
//                reset            synchronous active-high reset
//                clk_1Hz          1 Hz tick, asynchronous to userclock
//                switch2          set-mode flag (1 = time being set)
//                num0..num3 [3:0] BCD: min ones, min tens, hr ones, hr tens
//                an   [3:0]       active-low anodes, bit k = digit k
//                seg  [6:0]       active-low segments, bit 6..0 = a..g
//                dp               active-low decimal point (colon)
//  Revision    : 1.0  initial release
// ============================================================================
module display_scanner
   import watch_pkg::*;
#(
   parameter int unsigned REFRESH_DIV   = 50000,
   parameter bit          BLANK_LEADING = 1'b1
)
(
   input  logic       userclock,
   input  logic       reset,
   input  logic       clk_1Hz,
   input  logic       switch2,
   input  logic [3:0] num0,
   input  logic [3:0] num1,
   input  logic [3:0] num2,
   input  logic [3:0] num3,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam logic [19:0] C_DIV_LAST = REFRESH_DIV[19:0] - 20'd1;

   // ------------------------------------------------------------------------
   // Prescaler
   // ------------------------------------------------------------------------
   logic [19:0] cnt_q, cnt_d;
   logic        w_tc;

   assign w_tc = (cnt_q == C_DIV_LAST);

   always_comb begin
      cnt_d = w_tc ? 20'd0 : cnt_q + 20'd1;
   end

   always_ff @(posedge userclock) begin
      if (reset) cnt_q <= 20'd0;
      else       cnt_q <= cnt_d;
   end

   // ------------------------------------------------------------------------
   // Scan FSM: state register
   // ------------------------------------------------------------------------
   scan_state_t state_q, state_d;

   always_ff @(posedge userclock) begin
      if (reset) state_q <= ST_BLANK;
      else       state_q <= state_d;
   end

   // Scan FSM: next-state logic
   always_comb begin
      state_d = state_q;
      if (w_tc) begin
         case (state_q)
            ST_BLANK: state_d = ST_SCAN0;
            ST_SCAN0: state_d = ST_SCAN1;
            ST_SCAN1: state_d = ST_SCAN2;
            ST_SCAN2: state_d = ST_SCAN3;
            ST_SCAN3: state_d = ST_SCAN0;
            default:  state_d = ST_BLANK;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Frame snapshot: loaded on the edge that enters SCAN0. SCAN0 is never
   // re-entered from itself, so a terminal count targeting SCAN0 is an entry.
   // ------------------------------------------------------------------------
   logic [15:0] snap_q, snap_d;

   always_comb begin
      snap_d = snap_q;
      if (w_tc && (state_d == ST_SCAN0)) snap_d = {num3, num2, num1, num0};
   end

   always_ff @(posedge userclock) begin
      if (reset) snap_q <= 16'h0000;
      else       snap_q <= snap_d;
   end

   // ------------------------------------------------------------------------
   // Blink phase: 2-flop synchronizer, then an edge-detect flop on the
   // synchronized signal. Phase update is independent of the scan FSM, so
   // a toggle landing on a scan advance is never lost.
   // ------------------------------------------------------------------------
   logic [1:0] sync_q, sync_d;
   logic       prev_q, prev_d;
   logic       phase_q, phase_d;
   logic       w_rise;

   assign w_rise = sync_q[1] & ~prev_q;

   always_comb begin
      sync_d  = {sync_q[0], clk_1Hz};
      prev_d  = sync_q[1];
      phase_d = phase_q ^ w_rise;
   end

   always_ff @(posedge userclock) begin
      if (reset) begin
         sync_q  <= 2'b00;
         prev_q  <= 1'b0;
         phase_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         prev_q  <= prev_d;
         phase_q <= phase_d;
      end
   end

   // ------------------------------------------------------------------------
   // Digit select and decode
   // ------------------------------------------------------------------------
   logic [3:0] w_digit;
   logic [1:0] w_idx;
   logic       w_scan;
   logic [6:0] w_seg;
   logic       w_lead_blank;
   logic       w_blank;

   always_comb begin
      w_digit = 4'h0;
      w_idx   = 2'd0;
      w_scan  = 1'b0;
      case (state_q)
         ST_SCAN0: begin w_digit = snap_q[3:0];   w_idx = 2'd0; w_scan = 1'b1; end
         ST_SCAN1: begin w_digit = snap_q[7:4];   w_idx = 2'd1; w_scan = 1'b1; end
         ST_SCAN2: begin w_digit = snap_q[11:8];  w_idx = 2'd2; w_scan = 1'b1; end
         ST_SCAN3: begin w_digit = snap_q[15:12]; w_idx = 2'd3; w_scan = 1'b1; end
         default:  ;
      endcase
   end

   bcd_to_seg u_bcd_to_seg (
      .bcd_i (w_digit),
      .seg_o (w_seg)
   );

   generate
      if (BLANK_LEADING) begin : g_lead_blank
         assign w_lead_blank = (state_q == ST_SCAN3) && (snap_q[15:12] == 4'h0);
      end else begin : g_no_lead_blank
         assign w_lead_blank = 1'b0;
      end
   endgenerate

   // Set mode darkens the whole display during the off half of the blink.
   assign w_blank = (switch2 & ~phase_q) | w_lead_blank;

   // ------------------------------------------------------------------------
   // Output logic (registered below, so outputs lag the state by one cycle)
   // ------------------------------------------------------------------------
   logic [3:0] an_q, an_d;
   logic [6:0] seg_q, seg_d;
   logic       dp_q, dp_d;

   always_comb begin
      an_d  = C_AN_OFF;
      seg_d = C_SEG_OFF;
      dp_d  = 1'b1;
      if (w_scan && !w_blank) begin
         an_d  = ~(4'b0001 << w_idx);
         seg_d = w_seg;
         dp_d  = ~((state_q == ST_SCAN2) && phase_q);
      end
   end

   always_ff @(posedge userclock) begin
      if (reset) begin
         an_q  <= C_AN_OFF;
         seg_q <= C_SEG_OFF;
         dp_q  <= 1'b1;
      end else begin
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule : display_scanner
`default_nettype wire

// File: tb/tb_display_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_scanner
//  Description : Directed self-checking bench for display_scanner with
//                REFRESH_DIV = 4 and BLANK_LEADING = 1. Expected digit slots
//                are queued when stimulus is applied and popped when the
//                display reaches that slot; each slot is checked on its first
//                and last cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_display_scanner;
   import watch_pkg::*;

   logic       userclock = 1'b0;
   logic       reset     = 1'b1;
   logic       clk_1Hz   = 1'b0;
   logic       switch2   = 1'b0;
   logic [3:0] num0 = 4'h0, num1 = 4'h0, num2 = 4'h0, num3 = 4'h0;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string      tag;
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      bit         chk_seg;
   } exp_t;

   exp_t sbq[$];

   display_scanner #(
      .REFRESH_DIV   (4),
      .BLANK_LEADING (1'b1)
   ) dut (
      .userclock (userclock),
      .reset     (reset),
      .clk_1Hz   (clk_1Hz),
      .switch2   (switch2),
      .num0      (num0),
      .num1      (num1),
      .num2      (num2),
      .num3      (num3),
      .an        (an),
      .seg       (seg),
      .dp        (dp)
   );

   always #5 userclock = ~userclock;

   // Reference active-low patterns (a..g on bits 6..0)
   function automatic logic [6:0] pat(input logic [3:0] d);
      case (d)
         4'd0: return 7'b0000001;
         4'd1: return 7'b1001111;
         4'd2: return 7'b0010010;
         4'd3: return 7'b0000110;
         4'd4: return 7'b1001100;
         4'd5: return 7'b0100100;
         4'd6: return 7'b0100000;
         4'd7: return 7'b0001111;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0000100;
         default: return 7'b1111110;
      endcase
   endfunction

   task automatic tick();
      @(posedge userclock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected display for digit slot k holding value d
   task automatic push_slot(input string tag, input int k, input logic [3:0] d,
                            input logic sw, input logic ph);
      exp_t e;
      logic blanked;
      blanked   = (sw && !ph) || (k == 3 && d == 4'h0);
      e.tag     = tag;
      e.an      = blanked ? 4'b1111 : ~(4'b0001 << k);
      e.seg     = pat(d);
      e.chk_seg = !blanked;
      e.dp      = (k == 2 && ph && !blanked) ? 1'b0 : 1'b1;
      sbq.push_back(e);
   endtask

   task automatic push_frame(input string tag, input logic [15:0] nums,
                             input logic sw, input logic [3:0] ph);
      push_slot({tag, "_s0"}, 0, nums[3:0],   sw, ph[0]);
      push_slot({tag, "_s1"}, 1, nums[7:4],   sw, ph[1]);
      push_slot({tag, "_s2"}, 2, nums[11:8],  sw, ph[2]);
      push_slot({tag, "_s3"}, 3, nums[15:12], sw, ph[3]);
   endtask

   task automatic check_entry(input exp_t e, input string when);
      check({e.tag, when, "_an"}, 32'(an), 32'(e.an));
      check({e.tag, when, "_dp"}, 32'(dp), 32'(e.dp));
      if (e.chk_seg) check({e.tag, when, "_seg"}, 32'(seg), 32'(e.seg));
   endtask

   task automatic pop_entry(output exp_t e, output bit ok);
      ok = (sbq.size() != 0);
      if (ok) begin
         e = sbq.pop_front();
      end else begin
         checks++;
         errors++;
         $error("FAIL scoreboard_empty observed=%0d expected=%0d", 0, 1);
      end
   endtask

   // Called on the first output cycle of a slot; returns on the first
   // output cycle of the slot after the last one checked.
   task automatic run_slots(input int n);
      exp_t e;
      bit   ok;
      for (int i = 0; i < n; i++) begin
         pop_entry(e, ok);
         if (ok) check_entry(e, "_first");
         repeat (3) tick();
         if (ok) check_entry(e, "_last");
         tick();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e;
      bit   ok;

      // Reset state
      reset = 1'b1;
      tick();
      tick();
      check("rst_an",    32'(an),          32'hF);
      check("rst_seg",   32'(seg),         32'h7F);
      check("rst_dp",    32'(dp),          32'h1);
      check("rst_state", 32'(dut.state_q), 32'(ST_BLANK));
      check("rst_phase", 32'(dut.phase_q), 32'h0);

      // "1234", normal mode; first digit lit REFRESH_DIV+1 cycles after release
      {num3, num2, num1, num0} = 16'h1234;
      reset = 1'b0;
      repeat (4) tick();
      check("pre_first_an", 32'(an), 32'hF);
      tick();
      push_frame("f1", 16'h1234, 1'b0, 4'b0000);
      run_slots(3);
      // Change inputs during SCAN3: the current slot still shows the old frame
      {num3, num2, num1, num0} = 16'h09C4;
      run_slots(1);

      // Leading zero blanked, dash for 0xC
      push_frame("f2", 16'h09C4, 1'b0, 4'b0000);
      run_slots(2);
      // num0 4 -> 7 during SCAN2: appears only in the next frame
      num0 = 4'h7;
      run_slots(2);

      push_frame("f3", 16'h09C7, 1'b0, 4'b0000);
      run_slots(3);
      // Enter set mode; first 1 Hz rise lands on the SCAN3 -> SCAN0 advance
      {num3, num2, num1, num0} = 16'h1234;
      switch2 = 1'b1;
      clk_1Hz = 1'b1;
      run_slots(1);

      // Phase 1: all lit, colon on in SCAN2
      push_frame("f4", 16'h1234, 1'b1, 4'b1111);
      run_slots(1);
      clk_1Hz = 1'b0;
      run_slots(2);
      // Second rise lands on the next SCAN3 -> SCAN0 advance
      clk_1Hz = 1'b1;
      run_slots(1);

      // Phase 0 for slots 0,1 (blanked); third rise lands on SCAN1 -> SCAN2
      push_slot("f5_s0", 0, 4'h4, 1'b1, 1'b0);
      push_slot("f5_s1", 1, 4'h3, 1'b1, 1'b0);
      push_slot("f5_s2", 2, 4'h2, 1'b1, 1'b1);
      clk_1Hz = 1'b0;
      run_slots(1);
      clk_1Hz = 1'b1;
      run_slots(1);
      pop_entry(e, ok);
      if (ok) check_entry(e, "_first");

      // One-cycle reset in the middle of SCAN2
      reset   = 1'b1;
      clk_1Hz = 1'b0;
      switch2 = 1'b0;
      tick();
      check("mid_rst_an",    32'(an),          32'hF);
      check("mid_rst_seg",   32'(seg),         32'h7F);
      check("mid_rst_dp",    32'(dp),          32'h1);
      check("mid_rst_state", 32'(dut.state_q), 32'(ST_BLANK));
      check("mid_rst_phase", 32'(dut.phase_q), 32'h0);

      // Restart from BLANK with the same latency
      reset = 1'b0;
      repeat (4) tick();
      check("restart_pre_an", 32'(an), 32'hF);
      tick();
      push_frame("f6", 16'h1234, 1'b0, 4'b0000);
      run_slots(4);

      check("sb_drained", 32'(sbq.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_display_scanner
`default_nettype wire
